// File: rtl/dmem_pkg.sv
// Shared types, constants and helpers for the data-memory responder.
// The illegal-request check lives here so it can be reused by any dmem front end.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  // Wide enough to hold LATENCY-1 for the legal range 1..15.
  localparam int LAT_W = 4;

  localparam logic [3:0] MASK_B0 = 4'b0001;
  localparam logic [3:0] MASK_H0 = 4'b0011;
  localparam logic [3:0] MASK_H1 = 4'b1100;
  localparam logic [3:0] MASK_W  = 4'b1111;

  function automatic logic [31:0] lane_bits(input logic [3:0] mask);
    return {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  endfunction

  // The offset is an unsigned 32-bit difference, so addresses below the base wrap high and fail.
  function automatic logic req_illegal(input logic [31:0] addr,
                                       input logic        ren,
                                       input logic        wen,
                                       input logic [3:0]  mask,
                                       input logic [31:0] base,
                                       input logic [31:0] span);
    logic [31:0] offset;
    offset = addr - base;
    return (addr[1:0] != 2'b00) || (ren == wen) || (mask == 4'b0000) || (offset >= span);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane synchronous write and combinational read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we && i_be[b]) begin
        mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the hart's dmem port: accepts one word request, holds it LATENCY
// cycles, commits the array access on the last edge, then presents a held response.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_ren,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_mask,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  import dmem_pkg::*;

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) * 32'd4;

  state_t            state;
  state_t            state_next;
  logic [LAT_W-1:0]  cnt;
  logic [AW-1:0]     req_idx;
  logic              req_ren;
  logic              req_wen;
  logic              req_err;
  logic [31:0]       req_wdata;
  logic [3:0]        req_mask;
  logic [31:0]       arr_rdata;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              accept;
  logic              commit;

  // Ready is gated by reset so nothing can be accepted while reset is asserted.
  assign o_req_ready = (state == IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;
  assign commit      = (state == BUSY) && (cnt == '0);
  assign o_rsp_valid = (state == RESP);
  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_err   = rsp_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)      state_next = BUSY;
      BUSY:    if (cnt == '0)   state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // The legality check is resolved at accept so the commit edge only needs a flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt       <= '0;
      req_idx   <= '0;
      req_ren   <= 1'b0;
      req_wen   <= 1'b0;
      req_err   <= 1'b0;
      req_wdata <= '0;
      req_mask  <= '0;
    end else if (accept) begin
      cnt       <= LAT_W'(LATENCY - 1);
      req_idx   <= AW'((i_req_addr - BASE_ADDR) >> 2);
      req_ren   <= i_req_ren;
      req_wen   <= i_req_wen;
      req_err   <= req_illegal(i_req_addr, i_req_ren, i_req_wen, i_req_mask, BASE_ADDR, SPAN);
      req_wdata <= i_req_wdata;
      req_mask  <= i_req_mask;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_rdata <= (req_ren && !req_err) ? (arr_rdata & lane_bits(req_mask)) : '0;
      rsp_err   <= req_err;
    end else if ((state == RESP) && i_rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .i_clk  (i_clk),
    .i_we   (commit && req_wen && !req_err),
    .i_be   (req_mask),
    .i_addr (req_idx),
    .i_wdata(req_wdata),
    .o_rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench driving three responders (LATENCY 2, 1 and 15) in lockstep;
// expected responses are queued at issue and checked when each response rises.
module tb_dmem_responder;

  import dmem_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             rsp_ready;
  logic             ren;
  logic             wen;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic [3:0]       mask;
  logic [2:0]       req_ready;
  logic [2:0]       rsp_valid;
  logic [2:0]       rsp_err;
  logic [2:0][31:0] rsp_rdata;
  logic [2:0]       prev_valid = 3'b000;

  int   cyc    = 0;
  int   checks = 0;
  int   passed = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.LATENCY(2)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
    .i_req_addr(addr), .i_req_ren(ren), .i_req_wen(wen), .i_req_wdata(wdata),
    .i_req_mask(mask), .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

  dmem_responder #(.LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
    .i_req_addr(addr), .i_req_ren(ren), .i_req_wen(wen), .i_req_wdata(wdata),
    .i_req_mask(mask), .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

  dmem_responder #(.LATENCY(15)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[2]),
    .i_req_addr(addr), .i_req_ren(ren), .i_req_wen(wen), .i_req_wdata(wdata),
    .i_req_mask(mask), .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata[2]), .o_rsp_err(rsp_err[2]));

  function automatic int latOf(input int id);
    return (id == 0) ? 2 : (id == 1) ? 1 : 15;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic compareRsp(input int id, input exp_t x);
    checkOutput($sformatf("dut%0d rdata", id), rsp_rdata[id], x.rdata);
    checkOutput($sformatf("dut%0d err", id), 32'(rsp_err[id]), 32'(x.err));
    checkOutput($sformatf("dut%0d latency", id), 32'(cyc - x.acc), 32'(latOf(id)));
  endtask

  // Monitor: every rising response is matched against the oldest expectation for that DUT.
  always @(negedge clk) begin
    if (rsp_valid[0] && !prev_valid[0]) begin
      if (q0.size() == 0) failNow("dut0 spurious response");
      else begin e = q0.pop_front(); compareRsp(0, e); end
    end
    if (rsp_valid[1] && !prev_valid[1]) begin
      if (q1.size() == 0) failNow("dut1 spurious response");
      else begin e = q1.pop_front(); compareRsp(1, e); end
    end
    if (rsp_valid[2] && !prev_valid[2]) begin
      if (q2.size() == 0) failNow("dut2 spurious response");
      else begin e = q2.pop_front(); compareRsp(2, e); end
    end
    prev_valid <= rsp_valid;
  end

  task automatic applyStimulus(input logic [31:0] a, input logic r, input logic w,
                               input logic [31:0] d, input logic [3:0] m,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input bit push);
    int   waitc;
    exp_t x;
    waitc = 0;
    @(negedge clk);
    while (req_ready !== 3'b111 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) begin
      failNow("req_ready wait");
      return;
    end
    addr      = a;
    ren       = r;
    wen       = w;
    wdata     = d;
    mask      = m;
    req_valid = 1'b1;
    x.rdata   = exp_rdata;
    x.err     = exp_err;
    x.acc     = cyc + 1;
    if (push) begin
      q0.push_back(x);
      q1.push_back(x);
      q2.push_back(x);
    end
    @(negedge clk);
    req_valid = 1'b0;
    addr      = 32'hXXXX_XXXX;
    checkOutput("req_ready low after accept", 32'(req_ready), 32'h0);
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) failNow("response drain");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    ren       = 1'b0;
    wen       = 1'b0;
    addr      = '0;
    wdata     = '0;
    mask      = '0;
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'h0);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("reset rsp_rdata", rsp_rdata[0], 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle req_ready", 32'(req_ready), 32'h7);

    // Writes, reads and lane-masked merges.
    applyStimulus(32'h10, 1'b0, 1'b1, 32'hDEADBEEF, MASK_W,  32'h0,        1'b0, 1'b1);
    applyStimulus(32'h20, 1'b0, 1'b1, 32'h12345678, MASK_W,  32'h0,        1'b0, 1'b1);
    applyStimulus(32'h10, 1'b1, 1'b0, 32'h0,        MASK_W,  32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(32'h10, 1'b0, 1'b1, 32'h0000AB00, 4'b0010, 32'h0,        1'b0, 1'b1);
    applyStimulus(32'h10, 1'b1, 1'b0, 32'h0,        MASK_W,  32'hDEADABEF, 1'b0, 1'b1);
    applyStimulus(32'h10, 1'b1, 1'b0, 32'h0,        MASK_H1, 32'hDEAD0000, 1'b0, 1'b1);
    applyStimulus(32'h10, 1'b1, 1'b0, 32'h0,        MASK_B0, 32'h000000EF, 1'b0, 1'b1);
    applyStimulus(32'h10, 1'b1, 1'b0, 32'h0,        MASK_H0, 32'h0000ABEF, 1'b0, 1'b1);

    // Illegal requests: misaligned, out of range, both/neither op, empty mask.
    applyStimulus(32'h12,   1'b1, 1'b0, 32'h0,        MASK_W, 32'h0, 1'b1, 1'b1);
    applyStimulus(32'h1000, 1'b1, 1'b0, 32'h0,        MASK_W, 32'h0, 1'b1, 1'b1);
    applyStimulus(32'h10,   1'b1, 1'b1, 32'hFFFFFFFF, MASK_W, 32'h0, 1'b1, 1'b1);
    applyStimulus(32'h10,   1'b0, 1'b0, 32'hFFFFFFFF, MASK_W, 32'h0, 1'b1, 1'b1);
    applyStimulus(32'h10,   1'b0, 1'b1, 32'hFFFFFFFF, 4'b0,   32'h0, 1'b1, 1'b1);
    applyStimulus(32'h1010, 1'b0, 1'b1, 32'hFFFFFFFF, MASK_W, 32'h0, 1'b1, 1'b1);
    applyStimulus(32'h10,   1'b1, 1'b0, 32'h0,        MASK_W, 32'hDEADABEF, 1'b0, 1'b1);

    // Last word in range.
    applyStimulus(32'hFFC, 1'b0, 1'b1, 32'h0BADF00D, MASK_W, 32'h0,        1'b0, 1'b1);
    applyStimulus(32'hFFC, 1'b1, 1'b0, 32'h0,        MASK_W, 32'h0BADF00D, 1'b0, 1'b1);
    drain();

    // Response back-pressure: outputs must hold while the requester stalls.
    rsp_ready = 1'b0;
    applyStimulus(32'h20, 1'b1, 1'b0, 32'h0, MASK_W, 32'h12345678, 1'b0, 1'b1);
    begin
      int waitc;
      waitc = 0;
      while (rsp_valid !== 3'b111 && waitc < 100) begin
        @(negedge clk);
        waitc++;
      end
      if (waitc >= 100) failNow("hold wait rsp_valid");
    end
    repeat (5) begin
      @(negedge clk);
      checkOutput("hold rsp_valid", 32'(rsp_valid), 32'h7);
      checkOutput("hold rsp_rdata", rsp_rdata[0], 32'h12345678);
      checkOutput("hold req_ready", 32'(req_ready), 32'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("release rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("release req_ready", 32'(req_ready), 32'h7);
    drain();

    // Reset during BUSY of a write must drop the write and clear outputs at once.
    applyStimulus(32'h20, 1'b0, 1'b1, 32'hCAFEF00D, MASK_W, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("abort rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("abort req_ready", 32'(req_ready), 32'h0);
    checkOutput("abort rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("abort rsp_rdata", rsp_rdata[2], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h20, 1'b1, 1'b0, 32'h0, MASK_W, 32'h12345678, 1'b0, 1'b1);
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
